// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the two-requester APB master controller.
// Width defaults, PPROT bit positions and the bus sequencing state type.
package apb_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_SLV_SEL_BIT = 31;
    localparam int DEF_MAX_WAIT    = 16;

    localparam int PROT_WIDTH      = 3;
    localparam int PPROT_PRIV_BIT  = 0;
    localparam int PPROT_NSEC_BIT  = 1;
    localparam int PPROT_INSTR_BIT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter: with both requesters active, the one that did
// not win last time is granted; last_grant updates only when a grant is taken.
module apb_rr_arbiter
    import apb_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       last_grant
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Resetting to 1 makes requester 0 win the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master shared by two local requesters: round-robin grant, SETUP/ACCESS
// sequencing, PSEL decode from one address bit, and a bounded wait-state timeout.
module apb_master_ctrl
    import apb_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int SLV_SEL_BIT = DEF_SLV_SEL_BIT,
    parameter int MAX_WAIT    = DEF_MAX_WAIT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [1:0]                   req_write,
    input  logic [2*ADDR_WIDTH-1:0]      req_addr,
    input  logic [2*DATA_WIDTH-1:0]      req_wdata,
    input  logic [2*STRB_WIDTH-1:0]      req_strb,
    input  logic [2*PROT_WIDTH-1:0]      req_prot,
    output logic [1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         PSEL0,
    output logic                         PSEL1,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [ADDR_WIDTH-1:0]        PADDR,
    output logic [DATA_WIDTH-1:0]        PWDATA,
    output logic [STRB_WIDTH-1:0]        PSTRB,
    output logic [PROT_WIDTH-1:0]        PPROT,
    input  logic [DATA_WIDTH-1:0]        PRDATA,
    input  logic                         PREADY
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    apb_state_e state, state_nxt;

    logic [1:0]            gnt;
    logic                  last_grant;
    logic                  advance;
    logic                  finish;
    logic                  timeout;
    logic [WAIT_W-1:0]     wait_cnt;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_WIDTH-1:0] sel_strb;
    logic [PROT_WIDTH-1:0] sel_prot;
    logic                  sel_write;

    assign advance = (state == IDLE) && (req_valid != 2'b00);

    // The accept pulse must coincide with the grant cycle, so it is decoded
    // from req_valid directly; nothing on the APB side feeds it.
    assign req_ready = advance ? gnt : 2'b00;

    apb_rr_arbiter u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (req_valid),
        .advance    (advance),
        .gnt        (gnt),
        .last_grant (last_grant)
    );

    assign sel_addr  = gnt[1] ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : req_addr[ADDR_WIDTH-1:0];
    assign sel_wdata = gnt[1] ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    assign sel_strb  = gnt[1] ? req_strb[2*STRB_WIDTH-1:STRB_WIDTH]  : req_strb[STRB_WIDTH-1:0];
    assign sel_prot  = gnt[1] ? req_prot[2*PROT_WIDTH-1:PROT_WIDTH]  : req_prot[PROT_WIDTH-1:0];
    assign sel_write = gnt[1] ? req_write[1] : req_write[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (advance) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                // A ready slave wins over a timeout landing on the same cycle.
                if (PREADY) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    finish    = 1'b1;
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PSEL0     <= 1'b0;
            PSEL1     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            PPROT     <= '0;
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            wait_cnt  <= '0;
        end else begin
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;

            if (advance) begin
                PADDR  <= sel_addr;
                PWDATA <= sel_wdata;
                PSTRB  <= sel_write ? sel_strb : '0;
                PPROT  <= sel_prot;
                PWRITE <= sel_write;
                PSEL0  <= ~sel_addr[SLV_SEL_BIT];
                PSEL1  <= sel_addr[SLV_SEL_BIT];
            end

            if (state == SETUP) begin
                PENABLE <= 1'b1;
            end

            if (state == ACCESS) begin
                if (finish) begin
                    PSEL0     <= 1'b0;
                    PSEL1     <= 1'b0;
                    PENABLE   <= 1'b0;
                    wait_cnt  <= '0;
                    // last_grant still names the requester that owns this transfer.
                    rsp_valid <= last_grant ? 2'b10 : 2'b01;
                    rsp_err   <= timeout;
                    rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
                end else begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: directed scenarios plus randomized
// traffic, predicted by a transaction-level model of grant order and timing.
module tb_apb_master_ctrl;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int SW       = 4;
    localparam int MAX_WAIT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_ready, req_write, rsp_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [2*SW-1:0] req_strb;
    logic [5:0]      req_prot;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            PSEL0, PSEL1, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [SW-1:0]   PSTRB;
    logic [2:0]      PPROT;
    logic [DW-1:0]   PRDATA;
    logic            PREADY;

    int n_cmp = 0;
    int n_err = 0;

    // requester-side view: pending flag and request fields
    logic        pv [2];
    logic        pw [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic [3:0]  ps [2];
    logic [2:0]  pp [2];
    int          m_last = 1;

    apb_master_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW),
        .SLV_SEL_BIT(31),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_prot  (req_prot),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL0     (PSEL0),
        .PSEL1     (PSEL1),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        req_valid = {pv[1], pv[0]};
        req_write = {pw[1], pw[0]};
        req_addr  = {pa[1], pa[0]};
        req_wdata = {pd[1], pd[0]};
        req_strb  = {ps[1], ps[0]};
        req_prot  = {pp[1], pp[0]};
    endtask

    task automatic new_req(input int i);
        pv[i] = 1'b1;
        pw[i] = 1'($urandom_range(0, 1));
        pa[i] = $urandom;
        pd[i] = $urandom;
        ps[i] = 4'($urandom_range(0, 15));
        pp[i] = 3'($urandom_range(0, 7));
    endtask

    // Called at a negedge with the controller idle; returns at the negedge of
    // the response cycle (or just after reset release when aborting).
    task automatic xfer(input int w, input logic [31:0] rd, input int abort_at);
        int          g, acc, exp_len;
        logic [31:0] ea, ed;
        logic        ew, err_exp;
        logic [3:0]  es;
        logic [2:0]  ep;
        bit          done;

        if (!pv[0] && !pv[1]) new_req(0);
        if (pv[0] && pv[1]) g = (m_last == 1) ? 0 : 1;
        else                g = pv[1] ? 1 : 0;
        m_last = g;
        ea = pa[g]; ed = pd[g]; ew = pw[g]; es = ps[g]; ep = pp[g];
        err_exp = (w >= MAX_WAIT);
        exp_len = err_exp ? MAX_WAIT : w + 1;

        drive_reqs();
        #2;
        check_val("req_ready", req_ready, (g == 1) ? 2'b10 : 2'b01);

        @(negedge clk);
        check_val("setup_ctrl", {PSEL1, PSEL0, PENABLE}, {ea[31], ~ea[31], 1'b0});
        check_val("setup_paddr", PADDR, ea);
        check_val("setup_pwrite", PWRITE, ew);
        if (ew) check_val("setup_pwdata", PWDATA, ed);
        check_val("setup_pstrb", PSTRB, ew ? es : 4'h0);
        check_val("setup_pprot", PPROT, ep);
        check_val("rsp_pulse_width", rsp_valid, 2'b00);

        // requester saw req_ready: drop valid and scramble its port fields
        pv[g] = 1'b0;
        pa[g] = $urandom;
        pd[g] = $urandom;
        ps[g] = 4'($urandom_range(0, 15));
        pw[g] = 1'($urandom_range(0, 1));
        drive_reqs();
        PRDATA = rd;
        PREADY = 1'b0;

        acc  = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (PENABLE && (PSEL0 || PSEL1)) begin
                acc++;
                if (abort_at != 0 && acc == abort_at) begin
                    rst = 1'b1;
                    #1;
                    check_val("rst_async_drop", {PSEL1, PSEL0, PENABLE}, 3'b000);
                    for (int c = 0; c < 3; c++) begin
                        @(negedge clk);
                        check_val("rst_no_rsp", rsp_valid, 2'b00);
                    end
                    rst    = 1'b0;
                    PREADY = 1'b0;
                    m_last = 1;
                    @(negedge clk);
                    check_val("post_rst_idle", {rsp_valid, PSEL1, PSEL0, PENABLE}, 5'b0);
                    return;
                end
                check_val("access_hold", {PSEL1, PSEL0, PADDR}, {ea[31], ~ea[31], ea});
                PREADY = (acc == w + 1);
                if (acc > MAX_WAIT + 2) begin
                    check_val("access_budget", acc, exp_len);
                    done = 1;
                end
            end else begin
                done = 1;
            end
        end
        PREADY = 1'b0;

        check_val("access_len", acc, exp_len);
        check_val("rsp_valid", rsp_valid, (g == 1) ? 2'b10 : 2'b01);
        check_val("rsp_err", rsp_err, err_exp);
        check_val("rsp_rdata", rsp_rdata, (!ew && !err_exp) ? rd : 32'h0);
        check_val("idle_ctrl", {PSEL1, PSEL0, PENABLE}, 3'b000);
    endtask

    initial begin
        int w;
        for (int i = 0; i < 2; i++) begin
            pv[i] = 1'b0; pw[i] = 1'b0; pa[i] = '0; pd[i] = '0; ps[i] = '0; pp[i] = '0;
        end
        drive_reqs();
        PRDATA = '0;
        PREADY = 1'b0;
        rst    = 1'b1;

        #3;
        check_val("rst_ctrl", {PSEL1, PSEL0, PENABLE, PWRITE}, 4'b0);
        check_val("rst_rsp", {rsp_valid, rsp_err}, 3'b0);
        check_val("rst_rdata", rsp_rdata, 32'h0);
        check_val("rst_req_ready", req_ready, 2'b00);
        check_val("rst_apb_bus", {PADDR, PSTRB, PPROT}, 39'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single write from requester 0, zero wait states
        pv[0] = 1'b1; pw[0] = 1'b1; pa[0] = 32'h0000_0010; pd[0] = 32'hDEAD_BEEF;
        ps[0] = 4'hF; pp[0] = 3'b010;
        xfer(0, 32'hFFFF_0000, 0);

        // read from requester 1 to slave 1 with three wait states
        pv[1] = 1'b1; pw[1] = 1'b0; pa[1] = 32'h8000_0004; pd[1] = 32'h5555_AAAA;
        ps[1] = 4'hA; pp[1] = 3'b101;
        xfer(3, 32'h1234_5678, 0);

        // continuous contention: grants alternate 0,1,0,1
        new_req(0);
        new_req(1);
        for (int k = 0; k < 4; k++) begin
            xfer($urandom_range(0, 2), $urandom, 0);
            if (k < 3) new_req(m_last);
        end

        // timeout: slave never ready
        pv[0] = 1'b1; pw[0] = 1'b0; pa[0] = 32'h0000_0100;
        xfer(MAX_WAIT + 3, 32'hCAFE_F00D, 0);

        // just below the timeout boundary still completes normally
        new_req(1);
        xfer(MAX_WAIT - 1, 32'h0BAD_C0DE, 0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++)
                if (!pv[i] && $urandom_range(0, 2) != 0) new_req(i);
            if ($urandom_range(0, 7) == 0) w = $urandom_range(MAX_WAIT - 2, MAX_WAIT + 1);
            else                          w = $urandom_range(0, 4);
            xfer(w, $urandom, 0);
        end
        while (pv[0] || pv[1]) xfer($urandom_range(0, 3), $urandom, 0);

        // reset during ACCESS, then a clean minimum-length transfer
        pv[0] = 1'b1; pw[0] = 1'b0; pa[0] = 32'h0000_0040; pp[0] = 3'b000;
        xfer(MAX_WAIT + 5, 32'h7777_7777, 3);
        pv[1] = 1'b1; pw[1] = 1'b1; pa[1] = 32'h8000_0020; pd[1] = 32'h0102_0304;
        ps[1] = 4'h3; pp[1] = 3'b001;
        xfer(0, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
